// File: rtl/apb_rtc_alarm_if.sv
// ---------------------------------------------------------------------------
// apb_rtc_alarm_if
// APB3/APB4 bus bundle used by the RTC alarm block.
//   paddr    APB_AW  address (master -> slave)
//   psel     1       select
//   penable  1       access phase
//   pwrite   1       1 = write
//   pwdata   APB_DW  write data
//   pstrb    4       byte lane write strobes
//   pready   1       ready (slave -> master)
//   prdata   APB_DW  read data
//   pslverr  1       error response
// ---------------------------------------------------------------------------
interface apb_rtc_alarm_if #(
    parameter int APB_AW = 32,
    parameter int APB_DW = 32
);
    logic [APB_AW-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_DW-1:0] pwdata;
    logic [3:0]        pstrb;
    logic              pready;
    logic [APB_DW-1:0] prdata;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_rtc_alarm.sv
// ---------------------------------------------------------------------------
// apb_rtc_alarm
// APB real-time counter: prescaler, free-running tick counter and ALARM_QTY
// compare channels feeding one maskable level interrupt.
//
// Ports
//   pclk    input   APB clock, sole clock
//   prst_n  input   asynchronous active-low reset
//   s_apb   slave   APB bus (paddr[6:0] decoded, zero wait states)
//   irq     output  level interrupt, |(STATUS & MASK)
//
// Register map (byte offsets)
//   0x00 CTRL   bit0 EN, bit1 CLR (write-1 pulse, reads 0)
//   0x04 PRESC  0x08 COUNT  0x0C STATUS (W1C)  0x10 MASK
//   0x20+4*i ALARM[i]
//   0x40+4*i PERIOD[i]  only when RTC_PERIODIC_ALARM_EN is defined; a match
//            with non-zero PERIOD[i] advances ALARM[i] by PERIOD[i].
// ---------------------------------------------------------------------------
module apb_rtc_alarm #(
    parameter int APB_AW    = 32,
    parameter int APB_DW    = 32,
    parameter int CNT_W     = 32,
    parameter int PRESC_W   = 16,
    parameter int ALARM_QTY = 4
) (
    input  logic                pclk,
    input  logic                prst_n,
    apb_rtc_alarm_if.slave      s_apb,
    output logic                irq
);

    logic                 r_en;
    logic [PRESC_W-1:0]   r_presc;
    logic [PRESC_W-1:0]   r_pcnt;
    logic [CNT_W-1:0]     r_count;
    logic [ALARM_QTY-1:0] r_status;
    logic [ALARM_QTY-1:0] r_mask;
    logic [CNT_W-1:0]     r_alarm [ALARM_QTY];
`ifdef RTC_PERIODIC_ALARM_EN
    logic [CNT_W-1:0]     r_period [ALARM_QTY];
    logic                 w_sel_period;
`endif

    logic [6:0]           w_off;
    logic [2:0]           w_idx;
    logic                 w_idx_ok;
    logic                 w_access;
    logic                 w_wr;
    logic [APB_DW-1:0]    w_bmask;
    logic                 w_sel_ctrl, w_sel_presc, w_sel_count;
    logic                 w_sel_status, w_sel_mask, w_sel_alarm;
    logic                 w_err;
    logic [APB_DW-1:0]    w_rdata;
    logic                 w_clr;
    logic                 w_count_wr;
    logic                 w_tick;
    logic                 w_adv;
    logic [CNT_W-1:0]     w_count_inc;
    logic [ALARM_QTY-1:0] w_match;
    logic [ALARM_QTY-1:0] w_w1c;
    logic                 w_unused_paddr;

    function automatic logic [APB_DW-1:0] f_merge(
        input logic [APB_DW-1:0] old_v,
        input logic [APB_DW-1:0] new_v,
        input logic [APB_DW-1:0] bmask
    );
        return (old_v & ~bmask) | (new_v & bmask);
    endfunction

    assign w_off          = s_apb.paddr[6:0];
    assign w_idx          = w_off[4:2];
    assign w_access       = s_apb.psel & s_apb.penable;
    assign w_unused_paddr = &{1'b0, s_apb.paddr[APB_AW-1:7]};
    assign w_bmask        = {{8{s_apb.pstrb[3]}}, {8{s_apb.pstrb[2]}},
                             {8{s_apb.pstrb[1]}}, {8{s_apb.pstrb[0]}}};

    always_comb begin
        w_idx_ok = 1'b0;
        for (int i = 0; i < ALARM_QTY; i++) begin
            if (w_idx == 3'(i)) w_idx_ok = 1'b1;
        end
    end

    // Address decode; w_err covers misalignment, holes and absent channels.
    always_comb begin
        w_sel_ctrl   = 1'b0;
        w_sel_presc  = 1'b0;
        w_sel_count  = 1'b0;
        w_sel_status = 1'b0;
        w_sel_mask   = 1'b0;
        w_sel_alarm  = 1'b0;
`ifdef RTC_PERIODIC_ALARM_EN
        w_sel_period = 1'b0;
`endif
        w_err        = 1'b0;
        if (w_off[1:0] != 2'b00) begin
            w_err = 1'b1;
        end else if (w_off[6:5] == 2'b00) begin
            case (w_off[4:2])
                3'd0:    w_sel_ctrl   = 1'b1;
                3'd1:    w_sel_presc  = 1'b1;
                3'd2:    w_sel_count  = 1'b1;
                3'd3:    w_sel_status = 1'b1;
                3'd4:    w_sel_mask   = 1'b1;
                default: w_err        = 1'b1;
            endcase
        end else if (w_off[6:5] == 2'b01) begin
            if (w_idx_ok) w_sel_alarm = 1'b1;
            else          w_err       = 1'b1;
`ifdef RTC_PERIODIC_ALARM_EN
        end else if (w_off[6:5] == 2'b10) begin
            if (w_idx_ok) w_sel_period = 1'b1;
            else          w_err        = 1'b1;
`endif
        end else begin
            w_err = 1'b1;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel_ctrl)   w_rdata = APB_DW'(r_en);
        if (w_sel_presc)  w_rdata = APB_DW'(r_presc);
        if (w_sel_count)  w_rdata = APB_DW'(r_count);
        if (w_sel_status) w_rdata = APB_DW'(r_status);
        if (w_sel_mask)   w_rdata = APB_DW'(r_mask);
        for (int i = 0; i < ALARM_QTY; i++) begin
            if (w_sel_alarm && w_idx == 3'(i)) w_rdata = APB_DW'(r_alarm[i]);
`ifdef RTC_PERIODIC_ALARM_EN
            if (w_sel_period && w_idx == 3'(i)) w_rdata = APB_DW'(r_period[i]);
`endif
        end
    end

    assign s_apb.pready  = 1'b1;
    assign s_apb.prdata  = (w_access && !w_err) ? w_rdata : '0;
    assign s_apb.pslverr = w_access & w_err;

    assign w_wr        = w_access & s_apb.pwrite & ~w_err;
    assign w_clr       = w_wr & w_sel_ctrl & s_apb.pstrb[0] & s_apb.pwdata[1];
    assign w_count_wr  = w_wr & w_sel_count;
    assign w_tick      = r_en & (r_pcnt == r_presc);
    // A software COUNT write or CLR overrides the increment, so no match then.
    assign w_adv       = w_tick & ~w_count_wr & ~w_clr;
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_w1c       = (w_wr && w_sel_status) ?
                         ALARM_QTY'(s_apb.pwdata & w_bmask) : '0;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < ALARM_QTY; i++) begin
            w_match[i] = w_adv & (w_count_inc == r_alarm[i]);
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_en     <= 1'b0;
            r_presc  <= '0;
            r_pcnt   <= '0;
            r_count  <= '0;
            r_status <= '0;
            r_mask   <= '0;
            for (int i = 0; i < ALARM_QTY; i++) begin
                r_alarm[i] <= '0;
`ifdef RTC_PERIODIC_ALARM_EN
                r_period[i] <= '0;
`endif
            end
        end else begin
            if (w_wr && w_sel_ctrl && s_apb.pstrb[0]) r_en <= s_apb.pwdata[0];

            if (w_wr && w_sel_presc)
                r_presc <= PRESC_W'(f_merge(APB_DW'(r_presc), s_apb.pwdata, w_bmask));

            // Equality compare only: a PRESC lowered below pcnt waits for wrap.
            if (w_clr)         r_pcnt <= '0;
            else if (w_tick)   r_pcnt <= '0;
            else if (r_en)     r_pcnt <= r_pcnt + PRESC_W'(1);

            if (w_count_wr)
                r_count <= CNT_W'(f_merge(APB_DW'(r_count), s_apb.pwdata, w_bmask));
            else if (w_clr)
                r_count <= '0;
            else if (w_tick)
                r_count <= w_count_inc;

            // New match beats a same-cycle W1C of the same bit.
            r_status <= (r_status & ~w_w1c) | w_match;

            if (w_wr && w_sel_mask)
                r_mask <= ALARM_QTY'(f_merge(APB_DW'(r_mask), s_apb.pwdata, w_bmask));

            for (int i = 0; i < ALARM_QTY; i++) begin
                if (w_wr && w_sel_alarm && w_idx == 3'(i))
                    r_alarm[i] <= CNT_W'(f_merge(APB_DW'(r_alarm[i]), s_apb.pwdata, w_bmask));
`ifdef RTC_PERIODIC_ALARM_EN
                else if (w_match[i] && r_period[i] != '0)
                    r_alarm[i] <= r_alarm[i] + r_period[i];

                if (w_wr && w_sel_period && w_idx == 3'(i))
                    r_period[i] <= CNT_W'(f_merge(APB_DW'(r_period[i]), s_apb.pwdata, w_bmask));
`endif
            end
        end
    end

    assign irq = |(r_status & r_mask);

endmodule

// File: tb/tb_apb_rtc_alarm.sv
module tb_apb_rtc_alarm;

`ifdef RTC_PERIODIC_ALARM_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    logic pclk;
    logic prst_n;
    logic irq;

    apb_rtc_alarm_if #(.APB_AW(32), .APB_DW(32)) bus ();

    apb_rtc_alarm #(
        .APB_AW(32), .APB_DW(32), .CNT_W(32), .PRESC_W(16), .ALARM_QTY(4)
    ) dut (
        .pclk   (pclk),
        .prst_n (prst_n),
        .s_apb  (bus),
        .irq    (irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] exp_rd;
        logic        exp_err;
    } rd_vec_t;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } rw_vec_t;

    rd_vec_t rd_tab [14];
    rw_vec_t rw_tab [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the access-ending edge.
    task automatic apb_write(input logic [6:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic err);
        bus.paddr   = {25'd0, addr};
        bus.pwdata  = data;
        bus.pstrb   = strb;
        bus.pwrite  = 1'b1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(negedge pclk);
        bus.penable = 1'b1;
        #1;
        err = bus.pslverr;
        @(negedge pclk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [6:0] addr, output logic [31:0] data,
                            output logic err);
        bus.paddr   = {25'd0, addr};
        bus.pwrite  = 1'b0;
        bus.pstrb   = 4'h0;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(negedge pclk);
        bus.penable = 1'b1;
        #1;
        data = bus.prdata;
        err  = bus.pslverr;
        @(negedge pclk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic wr(input logic [6:0] addr, input logic [31:0] data);
        logic e;
        apb_write(addr, data, 4'hF, e);
    endtask

    task automatic rd_chk(input string name, input logic [6:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(addr, d, e);
        check(name, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e;

        rd_tab[0]  = '{7'h00, 32'h0, 1'b0};
        rd_tab[1]  = '{7'h04, 32'h0, 1'b0};
        rd_tab[2]  = '{7'h08, 32'h0, 1'b0};
        rd_tab[3]  = '{7'h0C, 32'h0, 1'b0};
        rd_tab[4]  = '{7'h10, 32'h0, 1'b0};
        rd_tab[5]  = '{7'h20, 32'h0, 1'b0};
        rd_tab[6]  = '{7'h24, 32'h0, 1'b0};
        rd_tab[7]  = '{7'h28, 32'h0, 1'b0};
        rd_tab[8]  = '{7'h2C, 32'h0, 1'b0};
        rd_tab[9]  = '{7'h14, 32'h0, 1'b1};
        rd_tab[10] = '{7'h30, 32'h0, 1'b1};
        rd_tab[11] = '{7'h02, 32'h0, 1'b1};
        rd_tab[12] = '{7'h7C, 32'h0, 1'b1};
        rd_tab[13] = '{7'h40, 32'h0, !PER_EN};

        rw_tab[0] = '{7'h04, 32'h12345678, 4'hF, 32'h00005678, 1'b0};
        rw_tab[1] = '{7'h10, 32'hFFFFFFFF, 4'hF, 32'h0000000F, 1'b0};
        rw_tab[2] = '{7'h2C, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0};
        rw_tab[3] = '{7'h2C, 32'h00000011, 4'h1, 32'hDEADBE11, 1'b0};
        rw_tab[4] = '{7'h20, 32'hCAFEF00D, 4'hC, 32'hCAFE0000, 1'b0};
        rw_tab[5] = '{7'h14, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1};
        rw_tab[6] = '{7'h30, 32'h00000001, 4'hF, 32'h00000000, 1'b1};
        rw_tab[7] = '{7'h0C, 32'h0000000F, 4'hF, 32'h00000000, 1'b0};
        rw_tab[8] = '{7'h10, 32'h00000000, 4'hF, 32'h00000000, 1'b0};
        rw_tab[9] = '{7'h04, 32'h00000000, 4'hF, 32'h00000000, 1'b0};

        bus.paddr   = '0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.pwdata  = '0;
        bus.pstrb   = 4'h0;
        prst_n      = 1'b0;
        repeat (3) @(negedge pclk);
        check("reset_irq", {31'd0, irq}, 32'h0);
        check("reset_pready", {31'd0, bus.pready}, 32'h1);
        prst_n = 1'b1;
        @(negedge pclk);

        // Reset-value and decode table.
        for (int i = 0; i < 14; i++) begin
            apb_read(rd_tab[i].addr, d, e);
            check($sformatf("rst_rd_data[%0h]", rd_tab[i].addr), d, rd_tab[i].exp_rd);
            check($sformatf("rst_rd_err[%0h]", rd_tab[i].addr), {31'd0, e}, {31'd0, rd_tab[i].exp_err});
        end

        // Write/readback table with strobes, field truncation and error writes.
        for (int i = 0; i < 10; i++) begin
            apb_write(rw_tab[i].addr, rw_tab[i].wdata, rw_tab[i].strb, e);
            check($sformatf("rw_wr_err[%0d]", i), {31'd0, e}, {31'd0, rw_tab[i].exp_err});
            apb_read(rw_tab[i].addr, d, e);
            check($sformatf("rw_rd_data[%0d]", i), d, rw_tab[i].exp_rd);
            check($sformatf("rw_rd_err[%0d]", i), {31'd0, e}, {31'd0, rw_tab[i].exp_err});
        end

        // PRESC=3, ALARM[0]=5: 5 ticks of 4 cycles.
        wr(7'h00, 32'h2);
        wr(7'h04, 32'd3);
        wr(7'h20, 32'd5);
        wr(7'h10, 32'h1);
        wr(7'h00, 32'h1);
        repeat (19) @(negedge pclk);
        check("tick_irq_before", {31'd0, irq}, 32'h0);
        @(negedge pclk);
        check("tick_irq_after", {31'd0, irq}, 32'h1);
        rd_chk("tick_count", 7'h08, 32'd5);
        rd_chk("tick_status", 7'h0C, 32'h1);
        wr(7'h0C, 32'h1);
        check("tick_irq_w1c", {31'd0, irq}, 32'h0);
        wr(7'h00, 32'h0);

        // Wrap through all-ones to 0 with PRESC=0.
        wr(7'h00, 32'h2);
        wr(7'h08, 32'hFFFF_FFFE);
        wr(7'h24, 32'h0);
        wr(7'h28, 32'h1000);
        wr(7'h2C, 32'h1000);
        wr(7'h0C, 32'hF);
        wr(7'h04, 32'h0);
        wr(7'h10, 32'h2);
        wr(7'h00, 32'h1);
        @(negedge pclk);
        check("wrap_irq_before", {31'd0, irq}, 32'h0);
        @(negedge pclk);
        check("wrap_irq_after", {31'd0, irq}, 32'h1);
        wr(7'h00, 32'h0);
        rd_chk("wrap_count", 7'h08, 32'd2);
        rd_chk("wrap_status", 7'h0C, 32'h2);

        // Byte-strobed COUNT write and out-of-range alarm read.
        wr(7'h00, 32'h2);
        apb_write(7'h08, 32'hAABBCCDD, 4'b0010, e);
        rd_chk("strb_count", 7'h08, 32'h0000CC00);
        apb_read(7'h7C, d, e);
        check("bad_alarm_err", {31'd0, e}, 32'h1);
        check("bad_alarm_data", d, 32'h0);

        // W1C of STATUS[0] on the same edge as a new ALARM[0] match.
        wr(7'h0C, 32'hF);
        wr(7'h00, 32'h2);
        wr(7'h08, 32'd9);
        wr(7'h20, 32'd12);
        wr(7'h10, 32'h1);
        wr(7'h00, 32'h1);
        @(negedge pclk);
        wr(7'h0C, 32'h1);
        check("setwins_irq", {31'd0, irq}, 32'h1);
        wr(7'h00, 32'h0);
        rd_chk("setwins_status", 7'h0C, 32'h1);

        // CLR zeroes COUNT but leaves STATUS.
        wr(7'h00, 32'h2);
        rd_chk("clr_count", 7'h08, 32'h0);
        rd_chk("clr_status", 7'h0C, 32'h1);
        rd_chk("clr_ctrl", 7'h00, 32'h0);

        // Reset asserted during the access phase of a STATUS read.
        bus.paddr   = 32'h0C;
        bus.pwrite  = 1'b0;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(negedge pclk);
        bus.penable = 1'b1;
        #1;
        check("midrst_rd_before", bus.prdata, 32'h1);
        prst_n = 1'b0;
        #1;
        check("midrst_rd_during", bus.prdata, 32'h0);
        check("midrst_err", {31'd0, bus.pslverr}, 32'h0);
        check("midrst_irq", {31'd0, irq}, 32'h0);
        @(negedge pclk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(negedge pclk);
        prst_n = 1'b1;
        @(negedge pclk);
        rd_chk("midrst_alarm0", 7'h20, 32'h0);
        rd_chk("midrst_mask", 7'h10, 32'h0);

`ifdef RTC_PERIODIC_ALARM_EN
        // Periodic re-arm: PRESC=1 so COUNT k is reached two cycles per step.
        wr(7'h04, 32'd1);
        wr(7'h28, 32'd4);
        wr(7'h48, 32'd4);
        wr(7'h10, 32'h4);
        wr(7'h00, 32'h1);
        repeat (7) @(negedge pclk);
        check("per_irq_before", {31'd0, irq}, 32'h0);
        @(negedge pclk);
        check("per_irq_first", {31'd0, irq}, 32'h1);
        rd_chk("per_alarm_8", 7'h28, 32'd8);
        wr(7'h0C, 32'h4);
        check("per_irq_w1c", {31'd0, irq}, 32'h0);
        repeat (3) @(negedge pclk);
        check("per_irq_before2", {31'd0, irq}, 32'h0);
        @(negedge pclk);
        check("per_irq_second", {31'd0, irq}, 32'h1);
        rd_chk("per_alarm_12", 7'h28, 32'd12);
        rd_chk("per_period", 7'h48, 32'd4);
        wr(7'h00, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
